scope_capture_core: RTL and testbench

- Parametrised successor to the single-channel 8-bit/512-sample capture logic.
- Single-clock pre/post-trigger capture engine with:
  - configurable sample width, buffer depth and pre-trigger length;
  - selectable trigger slope/mode;
  - streaming valid/ready readout of the captured record, oldest sample first.
- Sits between the sample source (ADC/flash register) and the UART/host readout path.

---
 rtl/scope_pkg.sv | 19 +
 rtl/scope_capture_ram.sv | 31 +++
 rtl/scope_capture_core.sv | 278 +++++++++++++++++++++++++++
 tb/tb_scope_capture_core.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
// Shared types for the scope capture engine: trigger modes and FSM states.
package scope_pkg;

    typedef enum logic [1:0] {
        TRIG_RISE   = 2'b00,
        TRIG_FALL   = 2'b01,
        TRIG_EITHER = 2'b10,
        TRIG_FORCE  = 2'b11
    } trig_mode_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRE       = 3'd1,
        WAIT_TRIG = 3'd2,
        POST      = 3'd3,
        READOUT   = 3'd4
    } cap_state_t;

endpackage

// File: rtl/scope_capture_ram.sv
// Simple dual-port capture buffer: one write port, one read port with a
// registered (1-cycle) read gated by a read enable.
module scope_capture_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rd_data_q <= mem_q[raddr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/scope_capture_core.sv
// Pre/post-trigger capture engine: ring-buffers samples around a trigger
// event, then streams the DEPTH-sample record out oldest sample first.
module scope_capture_core
    import scope_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              arm,
    input  logic              abort,
    input  logic [1:0]        trig_mode,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [ADDR_W-1:0] pretrig_len,
    output logic              busy,
    output logic              triggered,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    cap_state_t        state_q, state_d;
    trig_mode_t        mode_q, mode_d;
    logic [DATA_W-1:0] level_q, level_d;
    logic [ADDR_W-1:0] pretrig_q, pretrig_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic              rd_done_q, rd_done_d;
    logic              prev_valid_q, prev_valid_d;
    logic              above_prev_q, above_prev_d;
    logic              triggered_q, triggered_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_last_q, rd_last_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              skid_last_q, skid_last_d;

    logic              accept, above, edge_rise, edge_fall, trig_hit;
    logic              pop, rd_issue, ram_we;
    logic [1:0]        occ;
    logic [ADDR_W-1:0] pre_cnt_inc;
    logic [DATA_W-1:0] ram_rd_data;

    scope_capture_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .waddr   (wr_ptr_q),
        .wdata   (sample_data),
        .re      (rd_issue),
        .raddr   (rd_ptr_q),
        .rd_data (ram_rd_data)
    );

    // Readout handshake: a sample transfers on a cycle with out_valid & out_ready;
    // while out_valid & ~out_ready, out_data and out_last hold their values.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        level_d      = level_q;
        pretrig_d    = pretrig_q;
        wr_ptr_d     = wr_ptr_q;
        pre_cnt_d    = pre_cnt_q;
        post_cnt_d   = post_cnt_q;
        trig_addr_d  = trig_addr_q;
        rd_ptr_d     = rd_ptr_q;
        rd_cnt_d     = rd_cnt_q;
        rd_done_d    = rd_done_q;
        prev_valid_d = prev_valid_q;
        above_prev_d = above_prev_q;
        triggered_d  = triggered_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;
        rd_issue     = 1'b0;
        ram_we       = 1'b0;

        accept      = sample_valid && (state_q == PRE || state_q == WAIT_TRIG || state_q == POST);
        above       = (sample_data >= level_q);
        edge_rise   = above && !above_prev_q && prev_valid_q;
        edge_fall   = !above && above_prev_q && prev_valid_q;
        pre_cnt_inc = pre_cnt_q + 1'b1;
        pop         = out_valid_q && out_ready;
        occ         = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, rd_pend_q} - {1'b0, pop};

        case (mode_q)
            TRIG_RISE:   trig_hit = edge_rise;
            TRIG_FALL:   trig_hit = edge_fall;
            TRIG_EITHER: trig_hit = edge_rise || edge_fall;
            default:     trig_hit = 1'b1;
        endcase

        if (accept) begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (arm) begin
                    mode_d       = trig_mode_t'(trig_mode);
                    level_d      = trig_level;
                    pretrig_d    = (pretrig_len > LAST_IDX) ? LAST_IDX : pretrig_len;
                    pre_cnt_d    = '0;
                    prev_valid_d = 1'b0;
                    state_d      = (pretrig_len == '0) ? WAIT_TRIG : PRE;
                end
            end
            PRE: begin
                if (accept) begin
                    pre_cnt_d    = pre_cnt_inc;
                    prev_valid_d = 1'b1;
                    above_prev_d = above;
                    if (pre_cnt_inc == pretrig_q) begin
                        state_d = WAIT_TRIG;
                    end
                end
            end
            WAIT_TRIG: begin
                if (accept) begin
                    prev_valid_d = 1'b1;
                    above_prev_d = above;
                    if (trig_hit) begin
                        trig_addr_d = wr_ptr_q;
                        triggered_d = 1'b1;
                        post_cnt_d  = LAST_IDX - pretrig_q;
                        if (pretrig_q == LAST_IDX) begin
                            state_d   = READOUT;
                            rd_ptr_d  = wr_ptr_q - pretrig_q;
                            rd_cnt_d  = '0;
                            rd_done_d = 1'b0;
                        end else begin
                            state_d = POST;
                        end
                    end
                end
            end
            POST: begin
                if (accept) begin
                    post_cnt_d = post_cnt_q - 1'b1;
                    if (post_cnt_q == ADDR_W'(1)) begin
                        state_d   = READOUT;
                        rd_ptr_d  = trig_addr_q - pretrig_q;
                        rd_cnt_d  = '0;
                        rd_done_d = 1'b0;
                    end
                end
            end
            READOUT: begin
                // Only issue a read when the output and skid registers can absorb it.
                if (!rd_done_q && occ <= 2'd1) begin
                    rd_issue = 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    if (rd_cnt_q == LAST_IDX) begin
                        rd_done_d = 1'b1;
                    end
                end
                if (!out_valid_q || pop) begin
                    if (skid_valid_q) begin
                        out_valid_d  = 1'b1;
                        out_data_d   = skid_data_q;
                        out_last_d   = skid_last_q;
                        skid_valid_d = rd_pend_q;
                        skid_data_d  = ram_rd_data;
                        skid_last_d  = rd_last_q;
                    end else begin
                        out_valid_d = rd_pend_q;
                        out_data_d  = ram_rd_data;
                        out_last_d  = rd_last_q;
                    end
                end else if (rd_pend_q) begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = ram_rd_data;
                    skid_last_d  = rd_last_q;
                end
                if (pop && out_last_q) begin
                    state_d      = IDLE;
                    triggered_d  = 1'b0;
                    out_valid_d  = 1'b0;
                    out_last_d   = 1'b0;
                    skid_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        rd_pend_d = rd_issue;
        rd_last_d = rd_issue && (rd_cnt_q == LAST_IDX);

        if (abort) begin
            state_d      = IDLE;
            triggered_d  = 1'b0;
            out_valid_d  = 1'b0;
            out_last_d   = 1'b0;
            skid_valid_d = 1'b0;
            rd_pend_d    = 1'b0;
            rd_last_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            mode_q       <= TRIG_RISE;
            level_q      <= '0;
            pretrig_q    <= '0;
            wr_ptr_q     <= '0;
            pre_cnt_q    <= '0;
            post_cnt_q   <= '0;
            trig_addr_q  <= '0;
            rd_ptr_q     <= '0;
            rd_cnt_q     <= '0;
            rd_done_q    <= 1'b0;
            prev_valid_q <= 1'b0;
            above_prev_q <= 1'b0;
            triggered_q  <= 1'b0;
            rd_pend_q    <= 1'b0;
            rd_last_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            level_q      <= level_d;
            pretrig_q    <= pretrig_d;
            wr_ptr_q     <= wr_ptr_d;
            pre_cnt_q    <= pre_cnt_d;
            post_cnt_q   <= post_cnt_d;
            trig_addr_q  <= trig_addr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_cnt_q     <= rd_cnt_d;
            rd_done_q    <= rd_done_d;
            prev_valid_q <= prev_valid_d;
            above_prev_q <= above_prev_d;
            triggered_q  <= triggered_d;
            rd_pend_q    <= rd_pend_d;
            rd_last_q    <= rd_last_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign triggered = triggered_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_scope_capture_core.sv
// Bench for scope_capture_core at DATA_W=8, DEPTH=16: records every accepted
// sample, locates the trigger from the edge rules and predicts the record.
module tb_scope_capture_core;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_valid = 1'b0;
    logic [7:0] sample_data = '0;
    logic       arm = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] trig_mode = '0;
    logic [7:0] trig_level = '0;
    logic [3:0] pretrig_len = '0;
    logic       busy, triggered, out_valid, out_last;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0] hist[$];
    logic [7:0] exp_q[$];
    logic [7:0] got[DEPTH];
    bit         rpat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    scope_capture_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .arm          (arm),
        .abort        (abort),
        .trig_mode    (trig_mode),
        .trig_level   (trig_level),
        .pretrig_len  (pretrig_len),
        .busy         (busy),
        .triggered    (triggered),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Index of the trigger sample within hist, or -1 if none yet.
    function automatic int model_trig(input int mode, input int level, input int pretrig);
        bit a, ap;
        for (int i = pretrig; i < hist.size(); i++) begin
            if (mode == 3) return i;
            if (i == 0) continue;
            a  = (int'(hist[i]) >= level);
            ap = (int'(hist[i-1]) >= level);
            if ((mode == 0 || mode == 2) && a && !ap) return i;
            if ((mode == 1 || mode == 2) && !a && ap) return i;
        end
        return -1;
    endfunction

    task automatic do_capture(input int mode, input int level, input int pretrig,
                              input int gen, input int vmode, input int rmode,
                              input int budget, input int abort_at);
        int         cyc, trig, n, base;
        logic       v, rdy, held_v, held_l;
        logic [7:0] d, held_d;
        hist.delete();
        exp_q.delete();
        sample_valid = 1'b0;
        trig_mode    = 2'(mode);
        trig_level   = 8'(level);
        pretrig_len  = 4'(pretrig);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        cyc  = 0;
        trig = -1;
        forever begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            case (gen)
                0:       d = 8'(hist.size() * 16);
                1:       d = ((hist.size() / 3) % 2 == 0) ? 8'hFF : 8'h00;
                3:       d = 8'hFF;
                default: d = 8'($urandom_range(0, 255));
            endcase
            if (!v) d = 8'h5A;
            sample_valid = v;
            sample_data  = d;
            if (v) hist.push_back(d);
            tick();
            cyc++;
            trig = model_trig(mode, level, pretrig);
            if (trig >= 0 && hist.size() >= trig + DEPTH - pretrig) break;
            if ((trig < 0 && cyc >= budget) || cyc >= 2000) break;
        end
        sample_valid = 1'b0;
        if (trig < 0) begin
            chk("no_trig_busy", busy, 1);
            chk("no_trig_triggered", triggered, 0);
            abort = 1'b1;
            tick();
            abort = 1'b0;
            chk("abort_wait_busy", busy, 0);
            return;
        end
        if (hist.size() < trig + DEPTH - pretrig) begin
            chk("capture_timeout", hist.size(), trig + DEPTH - pretrig);
            return;
        end
        chk("triggered_set", triggered, 1);
        base = trig - pretrig;
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(hist[base+i]);
        n      = 0;
        held_v = 1'b0;
        held_d = '0;
        held_l = 1'b0;
        for (int k = 0; k < 400 && n < DEPTH; k++) begin
            if (held_v) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, held_d);
                chk("stall_last", out_last, held_l);
            end
            if (n == abort_at) begin
                out_ready = 1'b0;
                abort = 1'b1;
                arm   = 1'b1;
                tick();
                abort = 1'b0;
                arm   = 1'b0;
                chk("abort_rd_valid", out_valid, 0);
                chk("abort_rd_busy", busy, 0);
                chk("abort_rd_triggered", triggered, 0);
                tick();
                chk("abort_rd_arm_ignored", busy, 0);
                return;
            end
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = rpat[k % 6];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (out_valid && rdy) begin
                got[n] = out_data;
                chk("rd_data", out_data, exp_q.pop_front());
                chk("rd_last", out_last, (n == DEPTH - 1));
                n++;
            end
            held_v = out_valid && !rdy;
            held_d = out_data;
            held_l = out_last;
            tick();
        end
        out_ready = 1'b0;
        chk("rd_count", n, DEPTH);
        chk("end_busy", busy, 0);
        chk("end_triggered", triggered, 0);
        chk("end_valid", out_valid, 0);
    endtask

    initial begin
        #2;
        chk("reset_busy", busy, 0);
        chk("reset_triggered", triggered, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_last", out_last, 0);
        chk("reset_data", out_data, 0);
        rst = 1'b0;
        tick();

        // Rising edge on a ramp, 4 pre-trigger samples.
        do_capture(0, 'h80, 4, 0, 0, 0, 60, -1);
        chk("ramp_idx0", got[0], 'h40);
        chk("ramp_idx3", got[3], 'h70);
        chk("ramp_idx4", got[4], 'h80);
        chk("ramp_idx15", got[15], 'h30);

        // Falling edge on a square wave with sample_valid gaps.
        do_capture(1, 'h80, 5, 1, 1, 0, 100, -1);
        chk("fall_idx4", got[4], 'hFF);
        chk("fall_idx5", got[5], 'h00);

        // Force mode at both pre-trigger extremes.
        do_capture(3, 0, 0, 2, 0, 0, 60, -1);
        chk("force_pre0_idx0", got[0], hist[0]);
        do_capture(3, 0, 15, 2, 2, 0, 100, -1);
        chk("force_pre15_idx15", got[15], hist[15]);

        // First accepted sample must not produce an edge.
        do_capture(0, 'h80, 0, 3, 0, 0, 40, -1);

        // Backpressure pattern during readout.
        do_capture(2, 'h80, 6, 2, 0, 1, 200, -1);

        // Abort in WAIT_TRIG with a simultaneous arm.
        trig_mode   = 2'b00;
        trig_level  = 8'h80;
        pretrig_len = 4'd2;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample_valid = 1'b1;
            sample_data  = 8'h00;
            tick();
        end
        sample_valid = 1'b0;
        chk("wait_busy", busy, 1);
        abort = 1'b1;
        arm   = 1'b1;
        tick();
        abort = 1'b0;
        arm   = 1'b0;
        chk("abort_wait_idle", busy, 0);
        chk("abort_wait_valid", out_valid, 0);
        tick();
        chk("abort_wait_arm_ignored", busy, 0);

        // Abort in mid-readout, then a clean capture.
        do_capture(2, 'h60, 3, 2, 0, 0, 200, 7);
        do_capture(0, 'h80, 4, 0, 0, 0, 60, -1);
        chk("clean_idx4", got[4], 'h80);

        // Asynchronous reset while in POST.
        trig_mode   = 2'b11;
        pretrig_len = 4'd3;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sample_valid = 1'b1;
            sample_data  = 8'($urandom_range(0, 255));
            tick();
        end
        sample_valid = 1'b0;
        chk("post_triggered", triggered, 1);
        chk("post_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_triggered", triggered, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_last", out_last, 0);
        #1 rst = 1'b0;
        tick();

        // Randomized captures.
        for (int r = 0; r < 8; r++) begin
            do_capture($urandom_range(0, 2), $urandom_range('h20, 'hE0), $urandom_range(0, 15),
                       2, 2, 2, 300, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
